bcd_disp_scan: RTL and testbench
================================

// Module: bcd_disp_scan
// PURPOSE
//  Downstream consumer of the binary-to-BCD converter. Captures four BCD digits on
//  the converter's done pulse and drives a 4-digit common-anode 7-segment display.
//  Digits are time-multiplexed: one digit active per slot, slot length set by a
//  prescaler, with an all-off guard interval at the start of each slot (anti-ghosting).
// PARAMETERS
//  SLOT_CYC    50000  clk cycles per digit slot (>= GUARD_CYC+1); prescaler width = $clog2(SLOT_CYC)
//  GUARD_CYC   16     cycles at start of each slot with all anodes off (0 = no guard)
//  SEG_ACT_LOW 1      1: seg outputs active-low; 0: active-high
// PORTS
//  clk       in  1  system clock
//  reset_n   in  1  asynchronous active-low reset
//  load      in  1  single-cycle capture strobe (driven by converter done_tick)
//  bcd3      in  4  thousands digit
//  bcd2      in  4  hundreds digit
//  bcd1      in  4  tens digit
//  bcd0      in  4  units digit
//  an        out 4  digit enables, active-low, one-hot-low or 4'b1111 (an[0]=units)
//  seg       out 7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//  disp_vld  out 1  high once first load captured
//  bcd_err   out 1  high while captured data contains a digit > 9
// BEHAVIOUR
//  Reset (async assert, sync-released by clk edge): an=4'b1111, seg=all off, disp_vld=0,
//   bcd_err=0, shadow digits=0, digit index=0, prescaler=0, FSM=IDLE.
//  Capture: load=1 at edge N -> shadow regs updated at edge N; disp_vld=1 and bcd_err
//   (= any digit > 9) updated at the same edge. load while already scanning is legal; no stall.
//  FSM: IDLE -> SCAN on first load; SCAN persists until reset. IDLE: an=4'b1111, prescaler held at 0.
//  SCAN: prescaler counts 0..SLOT_CYC-1, wraps to 0; at wrap, idx advances 0->1->2->3->0.
//   First slot after IDLE->SCAN starts at idx=0, prescaler=0.
//  Outputs registered (one cycle after prescaler/idx/shadow state):
//   prescaler < GUARD_CYC -> an=4'b1111, seg=off; else an=~(4'b0001<<idx), seg=decode(shadow[idx]).
//  Decode (active-high hex, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F;
//   10..15 -> 40 (dash only). SEG_ACT_LOW=1 inverts all seven bits. "off" = all segments inactive.
//  Simultaneous load and slot wrap: the new idx slot shows the new shadow value.
//  Load mid-slot: current digit changes on the next output register update; slot timing is not reset.
//  Reset mid-scan: immediate blank, back to IDLE; the next load restarts at idx=0.
// CONFIGURATION
//  LZB_EN defined: leading-zero blanking; digit k (k=3..1) blanked (seg off, anode still
//   strobed) when shadow[k] and all higher digits are 0; digit 0 is always shown.
//   Invalid digits (>9) count as non-zero.
//  LZB_EN undefined: all four digits always shown, including leading zeros.
// TESTING (SLOT_CYC=4, GUARD_CYC=1, SEG_ACT_LOW=1 unless noted)
//  1 Reset then no load for 100 cycles -> an=1111, seg=7F, disp_vld=0 throughout.
//  2 load bcd=1,2,3,4 -> disp_vld=1; slots cycle an 1110/1101/1011/0111 with seg ~66,~4F,~5B,~06;
//    each slot is 3 active + 1 guard cycle (an=1111).
//  3 load 0,0,0,7: without LZB_EN, an=0111 shows seg=~3F; with LZB_EN, digits 3..1 off, an=1110 shows ~07.
//  4 load digit2=4'hC -> bcd_err=1, that slot seg=~40; next load 0,0,0,5 -> bcd_err=0.
//  5 load 9,8,7,6 then load 0,0,0,1 in the same cycle as the idx 1->2 wrap -> new slot shows digit2=0 (seg ~3F).
//  6 assert reset_n=0 mid-slot -> an=1111 asynchronously; release, load 5,5,5,5 -> scan restarts at an=1110.

Source files
------------

// File: rtl/bcd_disp_scan.sv
// Captures four BCD digits on load and time-multiplexes them onto a 4-digit
// common-anode 7-segment display with a blank guard at each slot start.
// Optional leading-zero blanking is enabled by defining LZB_EN.
module bcd_disp_scan #(
  parameter int SLOT_CYC    = 50000,
  parameter int GUARD_CYC   = 16,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       disp_vld,
  output logic       bcd_err
);

  localparam int         PW      = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;

  typedef enum logic {IDLE, SCAN} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    digit_q [4];
  logic [3:0]    digit_d [4];
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // A digit is blanked only when it and every more significant digit are zero.
  always_comb begin
    blank = '0;
`ifdef LZB_EN
    blank[3] = (digit_q[3] == 4'd0);
    blank[2] = blank[3] && (digit_q[2] == 4'd0);
    blank[1] = blank[2] && (digit_q[1] == 4'd0);
`endif
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    digit_d = digit_q;
    vld_d   = vld_q;
    err_d   = err_q;
    an_d    = 4'b1111;
    seg_d   = SEG_OFF;

    if (load) begin
      digit_d[3] = bcd3;
      digit_d[2] = bcd2;
      digit_d[1] = bcd1;
      digit_d[0] = bcd0;
      vld_d      = 1'b1;
      err_d      = (bcd3 > 4'd9) || (bcd2 > 4'd9) || (bcd1 > 4'd9) || (bcd0 > 4'd9);
      state_d    = SCAN;
    end

    // Output register follows the current slot state, so it lags by one cycle.
    if (state_q == SCAN) begin
      if (presc_q == PW'(SLOT_CYC - 1)) begin
        presc_d = '0;
        idx_d   = idx_q + 2'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
      if (int'(presc_q) >= GUARD_CYC) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank[idx_q] ? SEG_OFF
              : (SEG_ACT_LOW ? ~decode(digit_q[idx_q]) : decode(digit_q[idx_q]));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      idx_q   <= 2'd0;
      digit_q <= '{default: 4'd0};
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_OFF;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      digit_q <= digit_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign disp_vld = vld_q;
  assign bcd_err  = err_q;

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Directed, table-driven bench for bcd_disp_scan with SLOT_CYC=4, GUARD_CYC=1,
// active-low segments; expectations follow LZB_EN when it is defined.
module tb_bcd_disp_scan;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [3:0] bcd3, bcd2, bcd1, bcd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dispVld;
  logic       bcdErr;

  int errors = 0;
  int checks = 0;

`ifdef LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct {
    logic [3:0]      d3, d2, d1, d0;
    logic [3:0][6:0] segPlain;
    logic [3:0][6:0] segLzb;
    logic            err;
  } vec_t;

  vec_t vecs [5];

  bcd_disp_scan #(.SLOT_CYC(4), .GUARD_CYC(1), .SEG_ACT_LOW(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .load(load),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .an(an), .seg(seg), .disp_vld(dispVld), .bcd_err(bcdErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Presents digits for exactly one capture edge; returns on the following negedge.
  task automatic applyStimulus(input logic [3:0] a3, a2, a1, a0);
    @(negedge clk);
    bcd3 = a3; bcd2 = a2; bcd1 = a1; bcd0 = a0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Walks one full 16-cycle scan right after a capture that started from IDLE.
  task automatic scanCheck(input int v);
    logic [6:0] expSeg;
    logic [3:0] expAn;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (k % 4 == 0) begin
        expAn  = 4'b1111;
        expSeg = 7'h7F;
      end else begin
        expAn  = ~(4'b0001 << (k / 4));
        expSeg = LZB ? vecs[v].segLzb[k / 4] : vecs[v].segPlain[k / 4];
      end
      checkOutput($sformatf("v%0d k%0d an", v, k), {4'h0, an}, {4'h0, expAn});
      checkOutput($sformatf("v%0d k%0d seg", v, k), {1'b0, seg}, {1'b0, expSeg});
    end
  endtask

  initial begin
    vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0};
    vecs[1] = '{4'd0, 4'd0, 4'd0, 4'd7, {7'h40, 7'h40, 7'h40, 7'h78}, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0};
    vecs[2] = '{4'd0, 4'hC, 4'd0, 4'd5, {7'h40, 7'h3F, 7'h40, 7'h12}, {7'h7F, 7'h3F, 7'h40, 7'h12}, 1'b1};
    vecs[3] = '{4'd9, 4'd8, 4'd7, 4'd6, {7'h10, 7'h00, 7'h78, 7'h02}, {7'h10, 7'h00, 7'h78, 7'h02}, 1'b0};
    vecs[4] = '{4'd0, 4'd0, 4'd3, 4'd0, {7'h40, 7'h40, 7'h30, 7'h40}, {7'h7F, 7'h7F, 7'h30, 7'h40}, 1'b0};

    reset_n = 1'b0;
    load    = 1'b0;
    bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0;
    #12;
    checkOutput("reset an", {4'h0, an}, 8'h0F);
    checkOutput("reset seg", {1'b0, seg}, 8'h7F);
    checkOutput("reset vld", {7'h0, dispVld}, 8'h00);
    checkOutput("reset err", {7'h0, bcdErr}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    // Without a load the display must stay dark.
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("idle c%0d an", c), {4'h0, an}, 8'h0F);
      checkOutput($sformatf("idle c%0d seg", c), {1'b0, seg}, 8'h7F);
      checkOutput($sformatf("idle c%0d vld", c), {7'h0, dispVld}, 8'h00);
    end

    for (int v = 0; v < 5; v++) begin
      resetDut();
      applyStimulus(vecs[v].d3, vecs[v].d2, vecs[v].d1, vecs[v].d0);
      checkOutput($sformatf("v%0d vld", v), {7'h0, dispVld}, 8'h01);
      checkOutput($sformatf("v%0d err", v), {7'h0, bcdErr}, {7'h0, vecs[v].err});
      scanCheck(v);
      if (v == 2) begin
        applyStimulus(4'd0, 4'd0, 4'd0, 4'd5);
        checkOutput("err clear", {7'h0, bcdErr}, 8'h00);
        checkOutput("err clear vld", {7'h0, dispVld}, 8'h01);
      end
    end

    // Load coinciding with the idx 1->2 wrap: slot 2 must show the new digit.
    resetDut();
    applyStimulus(4'd9, 4'd8, 4'd7, 4'd6);
    for (int c = 0; c < 7; c++) @(posedge clk);
    @(negedge clk);
    bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd1;
    load = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("wrap old an", {4'h0, an}, 8'h0D);
    checkOutput("wrap old seg", {1'b0, seg}, 8'h78);
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("wrap guard an", {4'h0, an}, 8'h0F);
    @(posedge clk);
    #1;
    checkOutput("wrap new an", {4'h0, an}, 8'h0B);
    checkOutput("wrap new seg", {1'b0, seg}, LZB ? 8'h7F : 8'h40);

    // Reset asserted in the middle of an active cycle blanks immediately.
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async an", {4'h0, an}, 8'h0F);
    checkOutput("async seg", {1'b0, seg}, 8'h7F);
    checkOutput("async vld", {7'h0, dispVld}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(4'd5, 4'd5, 4'd5, 4'd5);
    @(posedge clk);
    #1;
    checkOutput("restart guard an", {4'h0, an}, 8'h0F);
    @(posedge clk);
    #1;
    checkOutput("restart an", {4'h0, an}, 8'h0E);
    checkOutput("restart seg", {1'b0, seg}, 8'h12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
